// File: rtl/l2_cache_nway.sv
// N-way set-associative write-back/write-allocate L2 cache, one word per line, true LRU.
// Optional event counters are built only when L2_STATS_EN is defined.
module l2_cache_nway #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int SETS       = 8,
    parameter int WAYS       = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    input  logic [2:0]            i_req_func3,
    output logic                  o_resp_valid,
    output logic [DATA_WIDTH-1:0] o_resp_rdata,
    output logic                  o_resp_hit,
    output logic                  o_mem_req_valid,
    input  logic                  i_mem_req_ready,
    output logic                  o_mem_req_we,
    output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
    output logic [DATA_WIDTH-1:0] o_mem_req_wdata,
    input  logic                  i_mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] i_mem_resp_rdata,
    output logic [31:0]           o_stat_hits,
    output logic [31:0]           o_stat_misses,
    output logic [31:0]           o_stat_wbs
);

    localparam int IDX  = $clog2(SETS);
    localparam int TAGW = ADDR_WIDTH - IDX - 2;
    localparam int WW   = $clog2(WAYS);

    typedef enum logic [2:0] {
        S_IDLE, S_TAG, S_WB, S_FILL_REQ, S_FILL_WAIT, S_RESP
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [2:0]            r_func3;
    logic [WW-1:0]         r_way;

    logic                  r_req_ready;
    logic                  r_resp_valid;
    logic                  r_resp_hit;
    logic [DATA_WIDTH-1:0] r_resp_rdata;
    logic                  r_mem_req_valid;
    logic                  r_mem_req_we;
    logic [ADDR_WIDTH-1:0] r_mem_req_addr;
    logic [DATA_WIDTH-1:0] r_mem_req_wdata;

    logic [WAYS-1:0]       r_valid [SETS];
    logic [WAYS-1:0]       r_dirty [SETS];
    logic [WW-1:0]         r_age   [SETS][WAYS];
    logic [TAGW-1:0]       r_tag   [SETS][WAYS];
    logic [DATA_WIDTH-1:0] r_data  [SETS][WAYS];

    logic [IDX-1:0]        w_set;
    logic [TAGW-1:0]       w_tag;
    logic                  w_hit;
    logic [WW-1:0]         w_hitWay;
    logic [WW-1:0]         w_victim;
    logic                  w_anyInvalid;
    logic [WW-1:0]         w_oldAge;
    logic [DATA_WIDTH-1:0] w_mergeSrc;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [ADDR_WIDTH-1:0] w_fillAddr;

    function automatic logic [DATA_WIDTH-1:0] storeMerge(
        input logic [DATA_WIDTH-1:0] oldWord,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [1:0]            offset,
        input logic [2:0]            func3
    );
        logic [DATA_WIDTH-1:0] res;
        res = oldWord;
        case (func3)
            3'b000:  res[int'(offset) * 8 +: 8] = wdata[7:0];
            3'b001:  res[int'(offset[1]) * 16 +: 16] = wdata[15:0];
            default: res = wdata;
        endcase
        return res;
    endfunction

    assign w_set      = r_addr[IDX+1:2];
    assign w_tag      = r_addr[ADDR_WIDTH-1:IDX+2];
    assign w_fillAddr = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    assign w_oldAge   = r_age[w_set][r_way];

    always_comb begin
        w_hit        = 1'b0;
        w_hitWay     = '0;
        w_victim     = '0;
        w_anyInvalid = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_set][w] && (r_tag[w_set][w] == w_tag)) begin
                w_hit    = 1'b1;
                w_hitWay = WW'(w);
            end
        end
        // Descending scan so the lowest-index invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_set][w]) begin
                w_victim     = WW'(w);
                w_anyInvalid = 1'b1;
            end
        end
        if (!w_anyInvalid) begin
            for (int w = 0; w < WAYS; w++) begin
                if (r_age[w_set][w] == WW'(WAYS - 1)) w_victim = WW'(w);
            end
        end
    end

    assign w_mergeSrc = (r_state == S_FILL_WAIT) ? i_mem_resp_rdata : r_data[w_set][w_hitWay];
    assign w_merged   = r_we ? storeMerge(w_mergeSrc, r_wdata, r_addr[1:0], r_func3) : w_mergeSrc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_addr          <= '0;
            r_we            <= 1'b0;
            r_wdata         <= '0;
            r_func3         <= '0;
            r_way           <= '0;
            r_req_ready     <= 1'b1;
            r_resp_valid    <= 1'b0;
            r_resp_hit      <= 1'b0;
            r_resp_rdata    <= '0;
            r_mem_req_valid <= 1'b0;
            r_mem_req_we    <= 1'b0;
            r_mem_req_addr  <= '0;
            r_mem_req_wdata <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                for (int w = 0; w < WAYS; w++) r_age[s][w] <= WW'(w);
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_addr      <= i_req_addr;
                        r_we        <= i_req_we;
                        r_wdata     <= i_req_wdata;
                        r_func3     <= i_req_func3;
                        r_req_ready <= 1'b0;
                        r_state     <= S_TAG;
                    end
                end
                S_TAG: begin
                    if (w_hit) begin
                        r_way        <= w_hitWay;
                        r_resp_valid <= 1'b1;
                        r_resp_hit   <= 1'b1;
                        r_resp_rdata <= w_merged;
                        r_state      <= S_RESP;
                    end else begin
                        r_way           <= w_victim;
                        r_mem_req_valid <= 1'b1;
                        if (r_valid[w_set][w_victim] && r_dirty[w_set][w_victim]) begin
                            r_mem_req_we    <= 1'b1;
                            r_mem_req_addr  <= {r_tag[w_set][w_victim], w_set, 2'b00};
                            r_mem_req_wdata <= r_data[w_set][w_victim];
                            r_state         <= S_WB;
                        end else begin
                            r_mem_req_we   <= 1'b0;
                            r_mem_req_addr <= w_fillAddr;
                            r_state        <= S_FILL_REQ;
                        end
                    end
                end
                S_WB: begin
                    if (i_mem_req_ready) begin
                        r_mem_req_we   <= 1'b0;
                        r_mem_req_addr <= w_fillAddr;
                        r_state        <= S_FILL_REQ;
                    end
                end
                S_FILL_REQ: begin
                    if (i_mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= S_FILL_WAIT;
                    end
                end
                S_FILL_WAIT: begin
                    if (i_mem_resp_valid) begin
                        r_valid[w_set][r_way] <= 1'b1;
                        r_dirty[w_set][r_way] <= 1'b0;
                        r_resp_valid          <= 1'b1;
                        r_resp_hit            <= 1'b0;
                        r_resp_rdata          <= w_merged;
                        r_state               <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    if (r_we) r_dirty[w_set][r_way] <= 1'b1;
                    // Ways younger than the accessed one age by one; older ways keep their age.
                    for (int w = 0; w < WAYS; w++) begin
                        if (WW'(w) == r_way)
                            r_age[w_set][w] <= '0;
                        else if (r_age[w_set][w] < w_oldAge)
                            r_age[w_set][w] <= r_age[w_set][w] + 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (r_state == S_FILL_WAIT && i_mem_resp_valid) begin
            r_tag[w_set][r_way]  <= w_tag;
            r_data[w_set][r_way] <= i_mem_resp_rdata;
        end else if (r_state == S_RESP) begin
            r_data[w_set][r_way] <= r_resp_rdata;
        end
    end

    assign o_req_ready     = r_req_ready;
    assign o_resp_valid    = r_resp_valid;
    assign o_resp_rdata    = r_resp_rdata;
    assign o_resp_hit      = r_resp_hit;
    assign o_mem_req_valid = r_mem_req_valid;
    assign o_mem_req_we    = r_mem_req_we;
    assign o_mem_req_addr  = r_mem_req_addr;
    assign o_mem_req_wdata = r_mem_req_wdata;

`ifdef L2_STATS_EN
    logic [31:0] r_stat_hits;
    logic [31:0] r_stat_misses;
    logic [31:0] r_stat_wbs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_hits   <= '0;
            r_stat_misses <= '0;
            r_stat_wbs    <= '0;
        end else begin
            if (r_state == S_RESP) begin
                if (r_resp_hit && r_stat_hits != 32'hFFFF_FFFF)
                    r_stat_hits <= r_stat_hits + 32'd1;
                if (!r_resp_hit && r_stat_misses != 32'hFFFF_FFFF)
                    r_stat_misses <= r_stat_misses + 32'd1;
            end
            if (r_state == S_WB && r_mem_req_valid && i_mem_req_ready && r_stat_wbs != 32'hFFFF_FFFF)
                r_stat_wbs <= r_stat_wbs + 32'd1;
        end
    end

    assign o_stat_hits   = r_stat_hits;
    assign o_stat_misses = r_stat_misses;
    assign o_stat_wbs    = r_stat_wbs;
`else
    assign o_stat_hits   = '0;
    assign o_stat_misses = '0;
    assign o_stat_wbs    = '0;
`endif

endmodule

// File: tb/tb_l2_cache_nway.sv
// Scoreboard bench for l2_cache_nway (SETS=8, WAYS=2) with a task-driven memory model.
module tb_l2_cache_nway;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic        reqWe = 1'b0;
    logic [31:0] reqAddr = '0;
    logic [31:0] reqWdata = '0;
    logic [2:0]  reqFunc3 = 3'b010;
    logic        respValid;
    logic [31:0] respRdata;
    logic        respHit;
    logic        memReqValid;
    logic        memReqReady = 1'b0;
    logic        memReqWe;
    logic [31:0] memReqAddr;
    logic [31:0] memReqWdata;
    logic        memRespValid = 1'b0;
    logic [31:0] memRespRdata = '0;
    logic [31:0] statHits, statMisses, statWbs;

    typedef struct {
        logic [31:0] rdata;
        logic        hit;
    } exp_t;

    exp_t expQ[$];
    int   checkCount = 0;
    int   passCount  = 0;
    int   cycle      = 0;
    int   hsCycle    = 0;
    int   respCycle  = 0;
    int   respCount  = 0;
    int   memReqSeen = 0;

    l2_cache_nway #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SETS(8), .WAYS(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_req_valid      (reqValid),
        .o_req_ready      (reqReady),
        .i_req_we         (reqWe),
        .i_req_addr       (reqAddr),
        .i_req_wdata      (reqWdata),
        .i_req_func3      (reqFunc3),
        .o_resp_valid     (respValid),
        .o_resp_rdata     (respRdata),
        .o_resp_hit       (respHit),
        .o_mem_req_valid  (memReqValid),
        .i_mem_req_ready  (memReqReady),
        .o_mem_req_we     (memReqWe),
        .o_mem_req_addr   (memReqAddr),
        .o_mem_req_wdata  (memReqWdata),
        .i_mem_resp_valid (memRespValid),
        .i_mem_resp_rdata (memRespRdata),
        .o_stat_hits      (statHits),
        .o_stat_misses    (statMisses),
        .o_stat_wbs       (statWbs)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        else
            passCount++;
    endtask

    // Responses are compared against the scoreboard away from the rising edge.
    always @(negedge clk) begin
        if (rst_n && memReqValid) memReqSeen++;
        if (rst_n && respValid) begin
            respCount++;
            respCycle = cycle;
            if (expQ.size() == 0) begin
                checkOutput("unexpectedResp", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("respRdata", respRdata, e.rdata);
                checkOutput("respHit", respHit, e.hit);
            end
        end
    end

    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [2:0] f3, input logic [31:0] expData, input logic expHit);
        int n;
        n = 0;
        @(negedge clk);
        while (!reqReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!reqReady) checkOutput("reqReadyTimeout", 64'd0, 64'd1);
        reqValid = 1'b1;
        reqWe    = we;
        reqAddr  = addr;
        reqWdata = wdata;
        reqFunc3 = f3;
        hsCycle  = cycle;
        expQ.push_back('{rdata: expData, hit: expHit});
        @(negedge clk);
        reqValid = 1'b0;
    endtask

    task automatic waitResp();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (expQ.size() != 0) begin
            checkOutput("respTimeout", 64'd0, 64'd1);
            expQ.delete();
        end
    endtask

    task automatic waitMemReq();
        int n;
        n = 0;
        while (!memReqValid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!memReqValid) checkOutput("memReqTimeout", 64'd0, 64'd1);
    endtask

    task automatic memReadReq(input logic [31:0] addr, input int stallCycles);
        logic [31:0] heldAddr;
        waitMemReq();
        checkOutput("fillWe", memReqWe, 1'b0);
        checkOutput("fillAddr", memReqAddr, addr);
        heldAddr = memReqAddr;
        for (int i = 0; i < stallCycles; i++) begin
            @(negedge clk);
            checkOutput("stallValid", memReqValid, 1'b1);
            checkOutput("stallAddr", memReqAddr, heldAddr);
            checkOutput("stallWe", memReqWe, 1'b0);
            checkOutput("stallReqReady", reqReady, 1'b0);
            checkOutput("stallRespValid", respValid, 1'b0);
        end
        memReqReady = 1'b1;
        @(negedge clk);
        memReqReady = 1'b0;
    endtask

    task automatic memRespond(input logic [31:0] data);
        memRespValid = 1'b1;
        memRespRdata = data;
        @(negedge clk);
        memRespValid = 1'b0;
        memRespRdata = '0;
    endtask

    task automatic memWrite(input logic [31:0] addr, input logic [31:0] data);
        waitMemReq();
        checkOutput("wbWe", memReqWe, 1'b1);
        checkOutput("wbAddr", memReqAddr, addr);
        checkOutput("wbData", memReqWdata, data);
        memReqReady = 1'b1;
        @(negedge clk);
        memReqReady = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "ReqReady"}, reqReady, 1'b1);
        checkOutput({tag, "RespValid"}, respValid, 1'b0);
        checkOutput({tag, "RespHit"}, respHit, 1'b0);
        checkOutput({tag, "RespRdata"}, respRdata, 32'h0);
        checkOutput({tag, "MemValid"}, memReqValid, 1'b0);
        checkOutput({tag, "MemWe"}, memReqWe, 1'b0);
        checkOutput({tag, "MemAddr"}, memReqAddr, 32'h0);
        checkOutput({tag, "MemWdata"}, memReqWdata, 32'h0);
        checkOutput({tag, "StatHits"}, statHits, 32'h0);
        checkOutput({tag, "StatWbs"}, statWbs, 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seenBefore;
        int respBefore;

        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;

        // Cold load then reload of 0x40.
        applyStimulus(1'b0, 32'h40, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0);
        memReadReq(32'h40, 0);
        memRespond(32'hDEADBEEF);
        waitResp();

        seenBefore = memReqSeen;
        applyStimulus(1'b0, 32'h40, 32'h0, 3'b010, 32'hDEADBEEF, 1'b1);
        waitResp();
        checkOutput("hitLatency", respCycle - hsCycle, 2);
        checkOutput("hitNoMemReq", memReqSeen - seenBefore, 0);

        // Byte and half stores merge into the resident line.
        applyStimulus(1'b1, 32'h41, 32'h000000AA, 3'b000, 32'hDEADAAEF, 1'b1);
        waitResp();
        applyStimulus(1'b1, 32'h42, 32'h00001234, 3'b001, 32'h1234AAEF, 1'b1);
        waitResp();

        // Fill the other way of set 0, then force eviction of the dirty line.
        applyStimulus(1'b0, 32'h60, 32'h0, 3'b010, 32'h11111111, 1'b0);
        memReadReq(32'h60, 0);
        memRespond(32'h11111111);
        waitResp();

        applyStimulus(1'b0, 32'h80, 32'h0, 3'b010, 32'h22222222, 1'b0);
        memWrite(32'h40, 32'h1234AAEF);
        memReadReq(32'h80, 0);
        memRespond(32'h22222222);
        waitResp();
`ifdef L2_STATS_EN
        checkOutput("statWbs", statWbs, 32'd1);
        checkOutput("statHits", statHits, 32'd3);
        checkOutput("statMisses", statMisses, 32'd3);
`endif

        // LRU victim is the clean 0x60 way; memory stalls for five cycles.
        applyStimulus(1'b0, 32'h100, 32'h0, 3'b010, 32'h33333333, 1'b0);
        memReadReq(32'h100, 5);
        memRespond(32'h33333333);
        waitResp();

        // Reset while waiting for fill data.
        applyStimulus(1'b0, 32'hC4, 32'h0, 3'b010, 32'h0, 1'b0);
        memReadReq(32'hC4, 0);
        @(negedge clk);
        expQ.delete();
        rst_n = 1'b0;
        #1;
        checkResetValues("midReset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        respBefore = respCount;
        memRespond(32'h77777777);
        repeat (3) @(negedge clk);
        checkOutput("postResetFillIgnored", respCount - respBefore, 0);

        applyStimulus(1'b0, 32'h40, 32'h0, 3'b010, 32'h44444444, 1'b0);
        memReadReq(32'h40, 0);
        memRespond(32'h44444444);
        waitResp();

        // Spurious fill data while idle must not disturb the line.
        respBefore = respCount;
        @(negedge clk);
        memRespond(32'h99999999);
        repeat (3) @(negedge clk);
        checkOutput("spuriousNoResp", respCount - respBefore, 0);
        checkOutput("spuriousReqReady", reqReady, 1'b1);
        applyStimulus(1'b0, 32'h40, 32'h0, 3'b010, 32'h44444444, 1'b1);
        waitResp();

        repeat (2) @(negedge clk);
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/l2_cache_nway.md
# l2_cache_nway

Parametrised, word-granular, N-way set-associative, write-back/write-allocate L2 cache that sits between the L1 data cache and main data memory. It accepts one request at a time from L1 through a valid/ready handshake and serves hits from its tag/data arrays. On a miss it runs a multi-cycle state machine: dirty-victim writeback, then line fill, through a valid/ready handshake to memory. Replacement is true LRU per set, for any power-of-two way count.

## Interface
Parameters:
- DATA_WIDTH, 32, word width; line = one word.
- ADDR_WIDTH, 32, byte address width.
- SETS, 8, number of sets (power of two, ≥2).
- WAYS, 2, associativity (power of two, ≥2).
- Derived: IDX = log2(SETS); TAG = ADDR_WIDTH−IDX−2; set = addr[IDX+1:2]; tag = addr[ADDR_WIDTH−1:IDX+2].

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  L1 request valid.
- req_ready  out  1  L2 can accept (IDLE only).
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data (LSB-aligned).
- req_func3  in  3  000 sb, 001 sh, 010 sw; others are treated as sw.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  DATA_WIDTH  line word after any store merge.
- resp_hit  out  1  1 if the request hit.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_we  out  1  1 = writeback, 0 = fill read.
- mem_req_addr  out  ADDR_WIDTH  word-aligned address.
- mem_req_wdata  out  DATA_WIDTH  writeback data.
- mem_resp_valid  in  1  fill data valid.
- mem_resp_rdata  in  DATA_WIDTH  fill data.
- stat_hits, stat_misses, stat_wbs  out  32 each  event counters (see Configuration).

## Operation
- Per set, per way: valid bit, dirty bit, tag, data word, and a log2(WAYS)-bit LRU age (0 = most recent).
- FSM states:
  - IDLE: req_ready=1. A handshake registers addr, we, wdata, and func3 → TAG.
  - TAG: compare all ways. On a hit → RESP. On a miss, select the victim. If the victim is valid and dirty → WB, else → FILL_REQ.
  - WB: mem_req_valid=1, we=1, addr={victim tag,set,2'b00}. On ready → FILL_REQ.
  - FILL_REQ: mem_req_valid=1, we=0, addr=req addr & ~3. On ready → FILL_WAIT.
  - FILL_WAIT: on mem_resp_valid, install data with valid=1, dirty=0, tag=req tag → RESP.
  - RESP: resp_valid=1. Apply store merge to the hit/filled way and set dirty=1 if a store. Update LRU → IDLE.
- Victim selection: the lowest-index invalid way; otherwise the way with age WAYS−1.
- LRU update: the accessed way's age becomes 0. Every way whose age was below the old age increments by 1. Other ways are unchanged.
- Store merge (byte lanes from addr[1:0]):
  - sb writes byte addr[1:0].
  - sh writes bytes {addr[1],1}:{addr[1],0}; addr[0] is ignored.
  - sw writes the full word; addr[1:0] are ignored.
- Only lanes covered by the store change.
- resp_rdata is the full word; sign/zero extension is done upstream.
- mem_resp_valid outside FILL_WAIT is ignored. req_valid outside IDLE is not accepted.

## Timing
- Reset values:
  - FSM in IDLE.
  - All valid and dirty bits 0; age[w]=w in every set.
  - req_ready=1; resp_valid=0, resp_hit=0, resp_rdata=0.
  - mem_req_valid=0, mem_req_we=0, mem_req_addr=0, mem_req_wdata=0.
  - stat_* = 0.
  - Data and tag arrays are not reset.
- Hit: handshake in cycle 0, TAG in cycle 1, resp_valid in cycle 2.
- Clean miss: resp_valid one cycle after the cycle mem_resp_valid is sampled.
- While mem_req_valid=1, mem_req_we, mem_req_addr and mem_req_wdata are held stable until ready.
- All outputs are registered or decoded from state; no combinational path from req_* to mem_*.
- Reset asserted mid-operation (any state) returns immediately to reset values. A pending memory request is dropped; memory must tolerate that.

## Configuration
- L2_STATS_EN defined:
  - stat_hits increments in RESP when hit.
  - stat_misses increments in RESP when miss.
  - stat_wbs increments on each WB handshake.
  - All counters saturate at 0xFFFF_FFFF.
- L2_STATS_EN undefined: stat_* are tied to 0 and no counter logic is built.

## Test plan
All cases use SETS=8, WAYS=2.
- **Cold load, then reload.** Load 0x40 misses. Expect a read handshake at addr 0x40. Memory returns 0xDEADBEEF, so resp_rdata=0xDEADBEEF and resp_hit=0. Reloading 0x40 gives resp_hit=1 with resp_valid two cycles after the handshake and no mem_req_valid.
- **Byte store merge.** sb of 0x000000AA to 0x41 on that line gives resp_rdata=0xDEADAAEF and marks the line dirty. sh of 0x1234 to 0x42 then gives 0x1234AAEF.
- **Dirty eviction.** After the store, load 0x60 (set 0, fill 0x11111111), then load 0x80 (set 0). Expect a writeback of addr 0x40, data 0x1234AAEF, before the read of 0x80; stat_wbs=1 with L2_STATS_EN.
- **Memory backpressure.** Hold mem_req_ready low for 5 cycles in FILL_REQ. mem_req_valid, mem_req_addr and mem_req_we stay stable, req_ready=0, and no resp_valid is issued.
- **Reset in FILL_WAIT.** Assert rst_n low in FILL_WAIT: all outputs return to reset values at once. A mem_resp_valid pulse after release is ignored, and a subsequent load 0x40 misses.
- **Spurious fill data.** A mem_resp_valid pulse while in IDLE changes no state and produces no resp_valid.
